// File: rtl/sha2_w_sched.sv
// sha2_w_sched: SHA-2 message schedule, 16-entry circular W buffer streaming W[0..ROUNDS-1].
module sha2_w_sched #(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 64,
  localparam int IW    = $clog2(ROUNDS - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_data,
  output logic [IW-1:0]    w_index,
  output logic             w_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [16];
  logic [3:0] cnt, tl;
  logic [IW-1:0] tn;
  logic [WIDTH-1:0] wn;
  logic load_beat, accept;
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction
  function automatic logic [WIDTH-1:0] s0(input logic [WIDTH-1:0] x);
    return (WIDTH == 32) ? rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3) : rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [WIDTH-1:0] s1(input logic [WIDTH-1:0] x);
    return (WIDTH == 32) ? rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10) : rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction
  assign in_ready  = state == LOAD;
  assign w_valid   = state == EXPAND;
  assign busy      = state != IDLE;
  assign w_last    = w_valid && w_index == IW'(ROUNDS - 1);
  assign load_beat = in_valid && in_ready;
  assign accept    = w_valid && w_ready;
  assign tl        = w_index[3:0];
  assign tn        = w_index + IW'(1);
  // buf[(t+1)&15] still holds W[t-15] at this point, so it is the W[t+1-16] operand
  assign wn = (tn < IW'(16)) ? mem[tn[3:0]]
            : s1(mem[tl - 4'd1]) + mem[tl - 4'd6] + s0(mem[tl + 4'd2]) + mem[tl + 4'd1];
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = LOAD;
    if (load_beat && cnt == 4'd15) state_n = EXPAND;
    if (accept && w_last) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (load_beat) mem[cnt] <= in_data;
    if (accept && !w_last && tn >= IW'(16)) mem[tn[3:0]] <= wn;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      w_data  <= '0;
      w_index <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= accept && w_last;
      if (state == IDLE && start) cnt <= '0;
      if (load_beat) cnt <= cnt + 4'd1;
      if (load_beat && cnt == 4'd15) begin
        w_data  <= (cnt == 4'd0) ? in_data : mem[0];
        w_index <= '0;
      end
      if (accept && !w_last) begin
        w_data  <= wn;
        w_index <= tn;
      end
    end
  end
endmodule

// File: tb/tb_sha2_w_sched.sv
// tb_sha2_w_sched: scoreboard bench for SHA-256 and SHA-512 schedule instances against a direct W[t] recurrence.
module tb_sha2_w_sched;
  logic clk = 0, rst = 1;
  logic start = 0, in_valid = 0, w_ready = 1;
  logic [31:0] in_data = '0, w_data;
  logic [5:0] w_index;
  logic in_ready, w_valid, w_last, busy, done;
  logic start_l = 0, in_valid_l = 0, w_ready_l = 1;
  logic [63:0] in_data_l = '0, w_data_l;
  logic [6:0] w_index_l;
  logic in_ready_l, w_valid_l, w_last_l, busy_l, done_l;
  typedef struct { int idx; logic [63:0] data; bit last; } exp_t;
  exp_t q32[$], q64[$];
  logic [63:0] msg [16];
  logic [63:0] wm [80];
  logic [63:0] got [80];
  logic [63:0] got_l [80];
  int n_cmp = 0, n_fail = 0;
  bit stall = 0;
  sha2_w_sched #(.WIDTH(32), .ROUNDS(64)) u32 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_index(w_index), .w_last(w_last),
    .busy(busy), .done(done));
  sha2_w_sched #(.WIDTH(64), .ROUNDS(80)) u64 (
    .clk(clk), .rst(rst), .start(start_l), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
    .w_valid(w_valid_l), .w_ready(w_ready_l), .w_data(w_data_l), .w_index(w_index_l), .w_last(w_last_l),
    .busy(busy_l), .done(done_l));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] mk = (w == 64) ? '1 : 64'hFFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & mk;
  endfunction
  function automatic logic [63:0] sg0(input logic [63:0] x, input int w);
    return (w == 32) ? rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3) : rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] sg1(input logic [63:0] x, input int w);
    return (w == 32) ? rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10) : rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction
  // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], then queued for the monitor
  task automatic model_push(input int w, input int rounds);
    logic [63:0] mk = (w == 64) ? '1 : 64'hFFFF_FFFF;
    exp_t e;
    for (int t = 0; t < rounds; t++) begin
      wm[t] = (t < 16) ? msg[t] & mk
            : (sg1(wm[t-2], w) + wm[t-7] + sg0(wm[t-15], w) + wm[t-16]) & mk;
      e.idx = t; e.data = wm[t]; e.last = (t == rounds - 1);
      if (w == 32) q32.push_back(e); else q64.push_back(e);
    end
  endtask
  task automatic rand_msg();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
  endtask
  task automatic abc_msg(input logic [63:0] w0);
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = w0; msg[15] = 64'h18;
  endtask
  always @(posedge clk) begin
    #1 w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  bit pend = 0, held = 0, pend_l = 0;
  logic [31:0] hd;
  logic [5:0] hi;
  always @(negedge clk) begin
    exp_t e;
    chk("done32", done, pend);
    pend = 0;
    if (held && w_valid && !rst) begin
      chk("hold_data", w_data, hd);
      chk("hold_index", w_index, hi);
    end
    held = 0;
    if (!rst && w_valid) begin
      if (!w_ready) begin
        held = 1; hd = w_data; hi = w_index;
      end else if (q32.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL w32_extra: got W[%0d]=%h, expected no output", w_index, w_data);
      end else begin
        e = q32.pop_front();
        chk("w32_index", w_index, e.idx);
        chk("w32_data", w_data, e.data);
        chk("w32_last", w_last, e.last);
        got[w_index] = w_data;
        pend = w_last;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    chk("done64", done_l, pend_l);
    pend_l = 0;
    if (!rst && w_valid_l && w_ready_l) begin
      if (q64.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL w64_extra: got W[%0d]=%h, expected no output", w_index_l, w_data_l);
      end else begin
        e = q64.pop_front();
        chk("w64_index", w_index_l, e.idx);
        chk("w64_data", w_data_l, e.data);
        chk("w64_last", w_last_l, e.last);
        got_l[w_index_l] = w_data_l;
        pend_l = w_last_l;
      end
    end
  end
  task automatic load32(input bit gaps, input bit noisy);
    int i = 0, guard = 0;
    bit v;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_to_load", {in_ready, busy}, 2'b11);
    while (i < 16 && guard < 1000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data = v ? msg[i][31:0] : $urandom;
      if (noisy) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (v) i++;
      guard++;
    end
    in_valid = 0; start = 0;
    chk("w0_latency", {w_valid, w_index}, 64'h40);
  endtask
  task automatic wait_done32(output int cyc, input bit noisy);
    cyc = 0;
    while (!done && cyc < 2000) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; in_valid = 0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL done32_timeout: got no done after %0d cycles, expected a done pulse", cyc);
    end
  endtask
  task automatic run64(output int cyc);
    start_l = 1;
    @(posedge clk); #1;
    start_l = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid_l = 1; in_data_l = msg[i];
      @(posedge clk); #1;
    end
    in_valid_l = 0;
    chk("w0_latency64", {w_valid_l, w_index_l}, 64'h80);
    cyc = 0;
    while (!done_l && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_l) begin
      n_cmp++; n_fail++;
      $display("FAIL done64_timeout: got no done after %0d cycles, expected a done pulse", cyc);
    end
  endtask
  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, w_valid, w_data, w_index, w_last, busy, done}, 64'h0);
    rst = 0;
    abc_msg(64'h61626380);
    model_push(32, 64);
    load32(0, 0);
    wait_done32(cyc, 0);
    chk("abc_block_cycles", cyc, 64);
    chk("abc_w16", got[16], 64'h61626380);
    chk("abc_w17", got[17], 64'h000F0000);
    chk("abc_w18", got[18], 64'h7DA86405);
    chk("abc_w19", got[19], 64'h600003C6);
    stall = 1;
    for (int b = 0; b < 3; b++) begin
      rand_msg();
      model_push(32, 64);
      load32(1, 1);
      wait_done32(cyc, 1);
    end
    stall = 0;
    rand_msg();
    model_push(32, 64);
    load32(0, 0);
    for (int k = 0; k < 200 && !(w_valid && w_index == 6'd30); k++) begin
      @(posedge clk); #1;
    end
    chk("reached_t30", {w_valid, w_index}, {58'h0, 1'b1, 6'd30});
    rst = 1;
    @(posedge clk); #1;
    chk("abort_outputs", {in_ready, w_valid, w_data, w_index, w_last, busy, done}, 64'h0);
    q32.delete();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", {w_valid, busy}, 64'h0);
    rand_msg();
    model_push(32, 64);
    load32(1, 0);
    wait_done32(cyc, 0);
    chk("q32_drained", q32.size(), 0);
    abc_msg(64'h6162638000000000);
    model_push(64, 80);
    run64(cyc);
    chk("abc512_block_cycles", cyc, 80);
    chk("abc512_w16", got_l[16], 64'h6162638000000000);
    chk("abc512_w17", got_l[17], 64'h00030000000000C0);
    rand_msg();
    model_push(64, 80);
    run64(cyc);
    chk("q64_drained", q64.size(), 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sha2_w_sched.md
Name: sha2_w_sched

Overview:
- Parametrised SHA-2 message-schedule buffer. Generalises the fixed 64x32 RAM used for W storage to 32-bit (SHA-256) and 64-bit (SHA-512) words.
- Accepts one 16-word padded message block over a valid/ready input stream.
- Expands it in place in a 16-entry circular buffer and streams W[0..ROUNDS-1] to the round core over a valid/ready output stream, with no bubbles.
- Sits between the padding/input unit and the compression round logic, next to the K-constant ROM.

Parameters:
- WIDTH, 32, word width. 32 selects SHA-256 sigma functions; 64 selects SHA-512 sigma functions. Other values are illegal.
- ROUNDS, 64, number of W words emitted per block. Must be 64 when WIDTH=32 and 80 when WIDTH=64.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a new block; honoured only in IDLE.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a message word.
- in_data  in  WIDTH  message word M[i], i = 0..15 in order.
- w_valid  out  1  w_data holds W[w_index].
- w_ready  in  1  consumer accepts the current W.
- w_data  out  WIDTH  schedule word, registered.
- w_index  out  clog2(ROUNDS-1)  index t of w_data.
- w_last  out  1  high with w_valid when t = ROUNDS-1.
- busy  out  1  high in LOAD and EXPAND.
- done  out  1  one-cycle pulse after the last W is accepted.

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE and clears in_ready, w_valid, w_data, w_index, w_last, busy, done and the internal counters. Buffer contents are not cleared; they are don't-care. Reset mid-LOAD or mid-EXPAND aborts the block; nothing further is emitted.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE:
  - in_ready=0, w_valid=0.
  - start=1 moves to LOAD with load count = 0.
  - in_valid and w_ready are ignored.
- LOAD:
  - in_ready=1, busy=1.
  - Each in_valid&in_ready beat writes buf[count] = in_data and increments count.
  - On the 16th beat: w_data <= buf[0], or in_data if count = 0 (not reachable in practice). State moves to EXPAND and t = 0.
  - W[0] is therefore visible in the cycle after the 16th input beat, with w_valid=1 and w_index=0.
- EXPAND:
  - in_ready=0, busy=1, w_valid=1.
  - w_data, w_index and w_last hold stable while w_ready=0.
  - On an accept (w_valid&w_ready) with t < ROUNDS-1, the next cycle presents W[t+1], giving a zero-bubble stream.
  - If t+1 < 16: W[t+1] = buf[t+1].
  - If t+1 >= 16: W[t+1] = s1(buf[(t-1)&15]) + buf[(t-6)&15] + s0(buf[(t-14)&15]) + buf[(t+1)&15], summed mod 2^WIDTH. The same edge writes W[t+1] into buf[(t+1)&15].
  - All four operands are already stored at the time of the accept; no bypass path is required.
  - On an accept with t = ROUNDS-1: state goes to IDLE, w_valid drops and done=1 for exactly one cycle.
- Sigma functions:
  - WIDTH=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WIDTH=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- start while busy is ignored. start in the same cycle as done is honoured, because the FSM is IDLE by then. in_valid outside LOAD is ignored.
- Minimum block time is 16 + ROUNDS cycles when in_valid and w_ready are held high.

Test Plan:
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 throughout:
  - W[0]=0x61626380 one cycle after the 16th beat.
  - W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[19]=0x600003C6.
  - 64 contiguous w_valid cycles, w_last on index 63, then a done pulse.
- WIDTH=64, ROUNDS=80, SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18):
  - W[16]=0x6162638000000000, W[17]=0x00030000000000C0.
  - w_last on index 79.
- Random w_ready backpressure (~50% duty): the W sequence is identical to the no-stall run, and w_data/w_index hold while stalled.
- in_valid gaps during LOAD: only valid beats are counted, and W[0..15] equal the words actually accepted.
- rst asserted at t=30 of EXPAND: the next cycle is IDLE with all outputs 0 and no done pulse. A new start then produces a correct block.
- start pulses during LOAD and EXPAND are ignored; start in the done cycle begins a new LOAD on the next cycle.
